// File: rtl/pal_cfg_loader.sv
// Purpose: serialises a host configuration bitstream onto the PAL CFG pin with a matching
//   shift-enable, producing exactly SR_LEN shifts per load, and flags when the PAL is programmed.
// Latency: handshake at edge e -> bit 0 on CFG_BIT with CFG_SHIFT=1 in cycle e+1; DONE one cycle
//   after the final shift.
// Backpressure: WR_READY only while the buffer is empty or on its last bit; host stalls
//   leave gaps where the chain holds.
// Ports: CLK/RST_N clock and async active-low reset; START/ABORT control; WR_VALID/WR_DATA/WR_READY
//   host word handshake (LSB shifted first); CFG_BIT/CFG_SHIFT to the PAL; BUSY/DONE/CFG_VALID status.
module pal_cfg_loader #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         ABORT,
  input  logic         WR_VALID,
  input  logic [W-1:0] WR_DATA,
  output logic         WR_READY,
  output logic         CFG_BIT,
  output logic         CFG_SHIFT,
  output logic         BUSY,
  output logic         DONE,
  output logic         CFG_VALID
);

  localparam int SR_LEN = 2*N*P + P*M;
  localparam int WORDS  = (SR_LEN + W - 1) / W;
  localparam int REM    = SR_LEN - (WORDS - 1) * W;
  localparam int BCW    = $clog2(SR_LEN + 1);
  localparam int WCW    = $clog2(WORDS + 1);
  localparam int KW     = $clog2(W + 1);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(SR_LEN - 1);
  localparam logic [WCW-1:0] WORDS_C   = WCW'(WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  localparam logic [KW-1:0]  K_FULL    = KW'(W);
  localparam logic [KW-1:0]  K_REM     = KW'(REM);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q;
  logic [W-1:0]   buf_q;
  logic [KW-1:0]  k_q;        // bits still to be shifted out of buf_q
  logic [BCW-1:0] bit_cnt_q;
  logic [WCW-1:0] wrd_cnt_q;
  logic           done_q;
  logic           cfg_valid_q;

  logic in_load;
  logic buf_vld;
  logic hs;
  logic last_shift;

  assign in_load = (state_q == S_LOAD);
  assign buf_vld = (k_q != '0);

  // ABORT masks the chain enable and the host handshake in the very cycle it is seen,
  // so the PAL never takes a bit from a load that is being cancelled.
  assign CFG_SHIFT = in_load & buf_vld & ~ABORT;
  // Ready on the last bit of a word lets the next word land with no bubble.
  assign WR_READY  = in_load & (k_q <= KW'(1)) & (wrd_cnt_q < WORDS_C) & ~ABORT;
  assign CFG_BIT   = buf_vld & buf_q[0];
  assign BUSY      = in_load;
  assign DONE      = done_q;
  assign CFG_VALID = cfg_valid_q;

  assign hs         = WR_VALID & WR_READY;
  assign last_shift = CFG_SHIFT & (bit_cnt_q == LAST_BIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      k_q         <= '0;
      bit_cnt_q   <= '0;
      wrd_cnt_q   <= '0;
      done_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_q     <= S_LOAD;
            buf_q       <= '0;
            k_q         <= '0;
            bit_cnt_q   <= '0;
            wrd_cnt_q   <= '0;
            cfg_valid_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ABORT) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            k_q     <= '0;
          end else begin
            if (CFG_SHIFT) begin
              buf_q     <= buf_q >> 1;
              k_q       <= k_q - KW'(1);
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
            // A new word overrides the shift of the final bit of the previous one;
            // bits above REM in the last word are never counted, so never shifted.
            if (hs) begin
              buf_q     <= WR_DATA;
              k_q       <= (wrd_cnt_q == LAST_WORD) ? K_REM : K_FULL;
              wrd_cnt_q <= wrd_cnt_q + WCW'(1);
            end
            if (last_shift) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cfg_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
